// File: rtl/trg_ack_pkg.sv
// Shared definitions for the trigger ACK monitor: event record layout and FSM encoding.
package trg_ack_pkg;

  localparam int unsigned NUM_CHAN   = 12;
  localparam int unsigned BITMAP_LSB = 0;
  localparam int unsigned COUNT_LSB  = 12;
  localparam int unsigned LAT_LSB    = 16;
  localparam int unsigned PASS_BIT   = 24;
  localparam int unsigned TO_BIT     = 25;
  localparam int unsigned SEQ_LSB    = 26;

  typedef enum logic [2:0] {
    StIdle   = 3'b001,
    StWait   = 3'b010,
    StReport = 3'b100
  } state_e;

  function automatic logic [3:0] popcount12(input logic [NUM_CHAN-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ack_sync_edge.sv
// Multi-stage synchronizer for one asynchronous ACK line with a registered rising-edge pulse.
module ack_sync_edge #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ack_i,
  output logic rise_o
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  prev_q, prev_d;
  logic                  rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], ack_i};
    prev_d = sync_q[SyncStages-1];
    rise_d = sync_q[SyncStages-1] & ~prev_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/trg_ack_monitor.sv
// Per-trigger ACK collector: opens an ACK window per trigger, builds a 32-bit event record
// and keeps trigger, good-event and drop counters.
module trg_ack_monitor
  import trg_ack_pkg::*;
#(
  parameter int unsigned N_SCROD     = 12,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               CLK_80MHZ,
  input  logic               RESET,
  input  logic [N_SCROD-1:0] TRG,
  input  logic [N_SCROD-1:0] ACK,
  input  logic [N_SCROD-1:0] TRG_MASK,
  input  logic [3:0]         MIN_SCRODS_REQUIRED,
  input  logic               CLEAR,
  output logic [31:0]        EVT_DATA,
  output logic               EVT_VALID,
  input  logic               EVT_READ,
  output logic [15:0]        TRG_COUNT,
  output logic [15:0]        GOOD_COUNT,
  output logic [7:0]         EVT_DROPPED
);

  logic [N_SCROD-1:0] ackrise;

  for (genvar i = 0; i < N_SCROD; i++) begin : g_sync
    ack_sync_edge #(
      .SyncStages(SYNC_STAGES)
    ) u_sync (
      .clk_i (CLK_80MHZ),
      .rst_i (RESET),
      .ack_i (ACK[i]),
      .rise_o(ackrise[i])
    );
  end

  state_e             state_q, state_d;
  logic [N_SCROD-1:0] trg_prev_q, trg_prev_d;
  logic [N_SCROD-1:0] bitmap_q, bitmap_d;
  logic [7:0]         timer_q, timer_d;
  logic [7:0]         latency_q, latency_d;
  logic               to_q, to_d;
  logic [5:0]         seq_q, seq_d;
  logic [31:0]        evt_data_q, evt_data_d;
  logic               evt_valid_q, evt_valid_d;
  logic [15:0]        trg_count_q, trg_count_d;
  logic [15:0]        good_count_q, good_count_d;
  logic [7:0]         dropped_q, dropped_d;

  logic               trg_start;
  logic [N_SCROD-1:0] new_bits;
  logic [N_SCROD-1:0] merged;
  logic [3:0]         count;
  logic               pass;
  logic [31:0]        record;
  logic               report;
  logic               trg_inc;
  logic               drop_trg;
  logic               drop_rec;
  logic [1:0]         drop_inc;
  logic [8:0]         drop_sum;

  always_comb begin
    trg_start = |(TRG & ~trg_prev_q);
    new_bits  = ackrise & TRG_MASK;
    merged    = bitmap_q | new_bits;
    count     = popcount12(bitmap_q);
    pass      = (count >= MIN_SCRODS_REQUIRED);

    record                            = '0;
    record[BITMAP_LSB +: NUM_CHAN]    = bitmap_q;
    record[COUNT_LSB +: 4]            = count;
    record[LAT_LSB +: 8]              = latency_q;
    record[PASS_BIT]                  = pass;
    record[TO_BIT]                    = to_q;
    record[SEQ_LSB +: 6]              = seq_q;

    state_d    = state_q;
    trg_prev_d = TRG;
    bitmap_d   = bitmap_q;
    timer_d    = timer_q;
    latency_d  = latency_q;
    to_d       = to_q;
    report     = 1'b0;
    trg_inc    = 1'b0;
    drop_trg   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (trg_start) begin
          state_d   = StWait;
          bitmap_d  = '0;
          timer_d   = '0;
          latency_d = '0;
          to_d      = 1'b0;
          trg_inc   = 1'b1;
        end
      end
      StWait: begin
        drop_trg = trg_start;
        timer_d  = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
        if (|new_bits) begin
          bitmap_d  = merged;
          latency_d = timer_q;
        end
        // Completion is tested first so it wins over a coincident timeout.
        if (merged == TRG_MASK) begin
          state_d = StReport;
          to_d    = 1'b0;
        end else if (timer_q == 8'(TIMEOUT)) begin
          state_d = StReport;
          to_d    = 1'b1;
        end
      end
      StReport: begin
        drop_trg = trg_start;
        report   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    evt_data_d  = evt_data_q;
    evt_valid_d = evt_valid_q;
    drop_rec    = 1'b0;
    if (report) begin
      if (!evt_valid_q || EVT_READ) begin
        evt_data_d  = record;
        evt_valid_d = 1'b1;
      end else begin
        drop_rec = 1'b1;
      end
    end else if (EVT_READ) begin
      evt_valid_d = 1'b0;
    end

    drop_inc = {1'b0, drop_trg} + {1'b0, drop_rec};
    drop_sum = {1'b0, dropped_q} + {7'b0, drop_inc};

    if (CLEAR) begin
      trg_count_d  = '0;
      good_count_d = '0;
      dropped_d    = '0;
      seq_d        = '0;
    end else begin
      trg_count_d  = trg_count_q + {15'b0, trg_inc};
      good_count_d = good_count_q + {15'b0, report & pass};
      dropped_d    = drop_sum[8] ? 8'hFF : drop_sum[7:0];
      seq_d        = seq_q + {5'b0, report};
    end
  end

  always_ff @(posedge CLK_80MHZ or posedge RESET) begin
    if (RESET) begin
      state_q      <= StIdle;
      trg_prev_q   <= '0;
      bitmap_q     <= '0;
      timer_q      <= '0;
      latency_q    <= '0;
      to_q         <= 1'b0;
      seq_q        <= '0;
      evt_data_q   <= '0;
      evt_valid_q  <= 1'b0;
      trg_count_q  <= '0;
      good_count_q <= '0;
      dropped_q    <= '0;
    end else begin
      state_q      <= state_d;
      trg_prev_q   <= trg_prev_d;
      bitmap_q     <= bitmap_d;
      timer_q      <= timer_d;
      latency_q    <= latency_d;
      to_q         <= to_d;
      seq_q        <= seq_d;
      evt_data_q   <= evt_data_d;
      evt_valid_q  <= evt_valid_d;
      trg_count_q  <= trg_count_d;
      good_count_q <= good_count_d;
      dropped_q    <= dropped_d;
    end
  end

  assign EVT_DATA    = evt_data_q;
  assign EVT_VALID   = evt_valid_q;
  assign TRG_COUNT   = trg_count_q;
  assign GOOD_COUNT  = good_count_q;
  assign EVT_DROPPED = dropped_q;

endmodule

// File: tb/tb_trg_ack_monitor.sv
// Scoreboard bench for trg_ack_monitor: directed triggers push hand-computed records,
// a negedge monitor pops and compares each record the DUT presents.
module tb_trg_ack_monitor;

  logic        clk;
  logic        rst;
  logic [11:0] trg;
  logic [11:0] ack;
  logic [11:0] mask;
  logic [3:0]  min_req;
  logic        clr;
  logic [31:0] evt_data;
  logic        evt_valid;
  logic        evt_read;
  logic [15:0] trg_count;
  logic [15:0] good_count;
  logic [7:0]  evt_dropped;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int tcyc   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rec_a;

  trg_ack_monitor #(
    .N_SCROD    (12),
    .TIMEOUT    (15),
    .SYNC_STAGES(2)
  ) dut (
    .CLK_80MHZ          (clk),
    .RESET              (rst),
    .TRG                (trg),
    .ACK                (ack),
    .TRG_MASK           (mask),
    .MIN_SCRODS_REQUIRED(min_req),
    .CLEAR              (clr),
    .EVT_DATA           (evt_data),
    .EVT_VALID          (evt_valid),
    .EVT_READ           (evt_read),
    .TRG_COUNT          (trg_count),
    .GOOD_COUNT         (good_count),
    .EVT_DROPPED        (evt_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mk(input logic [11:0] bm, input logic [3:0] cnt,
                                     input logic [7:0] lat, input logic ps, input logic to,
                                     input logic [5:0] seq);
    return {seq, to, ps, lat, cnt, bm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_trg(input logic [11:0] bits);
    tcyc = cyc;
    trg = bits;
    tick();
    trg = '0;
  endtask

  task automatic wait_valid(input string name, input int exp_delta);
    int n;
    n = 0;
    while (!evt_valid && n < 60) begin
      tick();
      n++;
    end
    check({name, " valid reached"}, {31'b0, evt_valid}, 32'd1);
    check({name, " cycles to valid"}, 32'(cyc - tcyc), 32'(exp_delta));
  endtask

  task automatic read_evt();
    evt_read = 1'b1;
    tick();
    evt_read = 1'b0;
    check("valid low after read", {31'b0, evt_valid}, 32'd0);
  endtask

  task automatic quiet();
    ack = '0;
    ticks(5);
  endtask

  // Monitor: a record is presented when valid rises or the held data changes.
  initial begin
    logic        prev_v;
    logic [31:0] prev_d;
    logic [31:0] e;
    prev_v = 1'b0;
    prev_d = '0;
    forever begin
      @(negedge clk);
      if (evt_valid && (!prev_v || evt_data != prev_d)) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected record: got 0x%0h, expected none", evt_data);
        end else begin
          e = exp_q.pop_front();
          check("record", evt_data, e);
        end
      end
      prev_v = evt_valid;
      prev_d = evt_data;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; trg = '0; ack = '0; mask = '0; min_req = '0; clr = 1'b0; evt_read = 1'b0;
    ticks(3);
    rst = 1'b0;
    tick();
    check("reset EVT_DATA", evt_data, 32'h0);
    check("reset EVT_VALID", {31'b0, evt_valid}, 32'd0);
    check("reset TRG_COUNT", {16'b0, trg_count}, 32'd0);
    check("reset GOOD_COUNT", {16'b0, good_count}, 32'd0);
    check("reset EVT_DROPPED", {24'b0, evt_dropped}, 32'd0);

    // Staggered ACKs on mask 0x00F; last edge at offset 10 gives latency 12.
    mask = 12'h00F; min_req = 4'd4;
    exp_q.push_back(mk(12'h00F, 4'd4, 8'd12, 1'b1, 1'b0, 6'd0));
    pulse_trg(12'h001);
    ack[0] = 1'b1; ticks(2);
    ack[1] = 1'b1; ticks(3);
    ack[2] = 1'b1; ticks(4);
    ack[3] = 1'b1;
    wait_valid("t1", 15);
    tick();
    check("t1 GOOD_COUNT", {16'b0, good_count}, 32'd1);
    check("t1 TRG_COUNT", {16'b0, trg_count}, 32'd1);
    read_evt();
    quiet();

    // Nine of twelve ACKs: full timeout, REPORT 17 cycles after the start.
    mask = 12'hFFF; min_req = 4'd10;
    exp_q.push_back(mk(12'h1FF, 4'd9, 8'd4, 1'b0, 1'b1, 6'd1));
    pulse_trg(12'h004);
    tick();
    ack = 12'h1FF;
    wait_valid("t2", 18);
    check("t2 GOOD_COUNT", {16'b0, good_count}, 32'd1);
    check("t2 TRG_COUNT", {16'b0, trg_count}, 32'd2);
    read_evt();
    quiet();

    // Second record while full is lost; the held record stays.
    clr = 1'b1; tick(); clr = 1'b0;
    check("clear TRG_COUNT", {16'b0, trg_count}, 32'd0);
    mask = 12'h001; min_req = 4'd1;
    rec_a = mk(12'h001, 4'd1, 8'd3, 1'b1, 1'b0, 6'd0);
    exp_q.push_back(rec_a);
    pulse_trg(12'h001);
    ack[0] = 1'b1;
    wait_valid("t3a", 6);
    quiet();
    pulse_trg(12'h001);
    ack[0] = 1'b1;
    ticks(10);
    check("t3 EVT_DROPPED", {24'b0, evt_dropped}, 32'd1);
    check("t3 held data", evt_data, rec_a);
    quiet();
    read_evt();
    exp_q.push_back(mk(12'h001, 4'd1, 8'd3, 1'b1, 1'b0, 6'd2));
    pulse_trg(12'h001);
    ack[0] = 1'b1;
    wait_valid("t3c", 6);
    check("t3 GOOD_COUNT", {16'b0, good_count}, 32'd3);
    check("t3 TRG_COUNT", {16'b0, trg_count}, 32'd3);
    read_evt();
    quiet();

    // Retrigger during WAIT is dropped; unmasked ACK2 is ignored.
    clr = 1'b1; tick(); clr = 1'b0;
    mask = 12'h003; min_req = 4'd2;
    exp_q.push_back(mk(12'h003, 4'd2, 8'd7, 1'b1, 1'b0, 6'd0));
    pulse_trg(12'h001);
    ack[2] = 1'b1; tick();
    ack[0] = 1'b1; tick();
    trg = 12'h001; tick();
    trg = '0; tick();
    ack[1] = 1'b1;
    wait_valid("t4", 10);
    check("t4 TRG_COUNT", {16'b0, trg_count}, 32'd1);
    check("t4 EVT_DROPPED", {24'b0, evt_dropped}, 32'd1);
    read_evt();
    quiet();

    // Read coincident with REPORT while full: reload, no drop.
    mask = 12'h001; min_req = 4'd1;
    exp_q.push_back(mk(12'h001, 4'd1, 8'd3, 1'b1, 1'b0, 6'd1));
    pulse_trg(12'h001);
    ack[0] = 1'b1;
    wait_valid("t5d", 6);
    quiet();
    exp_q.push_back(mk(12'h001, 4'd1, 8'd3, 1'b1, 1'b0, 6'd2));
    pulse_trg(12'h001);
    ack[0] = 1'b1;
    ticks(4);
    evt_read = 1'b1; tick(); evt_read = 1'b0;
    tick();
    check("t5 EVT_DROPPED", {24'b0, evt_dropped}, 32'd1);
    check("t5 valid kept", {31'b0, evt_valid}, 32'd1);
    check("t5 GOOD_COUNT", {16'b0, good_count}, 32'd3);
    quiet();
    read_evt();

    // CLEAR coincident with a trigger start.
    exp_q.push_back(mk(12'h001, 4'd1, 8'd3, 1'b1, 1'b0, 6'd0));
    tcyc = cyc;
    trg = 12'h001; clr = 1'b1; tick(); trg = '0; clr = 1'b0;
    check("clear+start TRG_COUNT", {16'b0, trg_count}, 32'd0);
    ack[0] = 1'b1;
    wait_valid("t5f", 6);
    quiet();

    // Reset mid-WAIT with a record still held.
    pulse_trg(12'h001);
    ticks(3);
    rst = 1'b1;
    #1;
    check("rst EVT_DATA", evt_data, 32'h0);
    check("rst EVT_VALID", {31'b0, evt_valid}, 32'd0);
    check("rst GOOD_COUNT", {16'b0, good_count}, 32'd0);
    check("rst EVT_DROPPED", {24'b0, evt_dropped}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    exp_q.push_back(mk(12'h001, 4'd1, 8'd3, 1'b1, 1'b0, 6'd0));
    pulse_trg(12'h001);
    ack[0] = 1'b1;
    wait_valid("t6", 6);
    check("t6 TRG_COUNT", {16'b0, trg_count}, 32'd1);
    read_evt();
    quiet();

    // Empty mask, MIN=0, TRG held high: one start, immediate completion.
    mask = 12'h000; min_req = 4'd0;
    exp_q.push_back(mk(12'h000, 4'd0, 8'd0, 1'b1, 1'b0, 6'd1));
    tcyc = cyc;
    trg = 12'h001;
    tick();
    wait_valid("t7", 3);
    ticks(3);
    check("t7 TRG_COUNT", {16'b0, trg_count}, 32'd2);
    check("t7 EVT_DROPPED", {24'b0, evt_dropped}, 32'd0);
    trg = '0;
    read_evt();

    ticks(3);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
